// File: rtl/vec_alu_wb_buffer_if.sv
// Writeback handshake bundle between the vector ALU lanes,
// the buffer and the register file write port.
interface vec_alu_wb_buffer_if #(
  parameter int LANES = 4,
  parameter int W     = 16
) ();
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_result;
  logic [LANES*4-1:0] in_flags;
  logic [4:0]         in_rd;
  logic               in_scalar;

  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_data;
  logic [4:0]         out_rd;
  logic [LANES-1:0]   out_we_mask;
  logic [3:0]         out_flags;

  modport master (
    output in_valid,
    input  in_ready,
    output in_result,
    output in_flags,
    output in_rd,
    output in_scalar,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_rd,
    input  out_we_mask,
    input  out_flags
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_result,
    input  in_flags,
    input  in_rd,
    input  in_scalar,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_rd,
    output out_we_mask,
    output out_flags
  );
endinterface

// File: rtl/vec_alu_wb_buffer.sv
// Two-entry writeback FIFO for vector ALU results, with
// combined per-op flags, sticky flag accumulation and retire count.
module vec_alu_wb_buffer #(
  parameter int LANES = 4,
  parameter int W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vec_alu_wb_buffer_if.slave   bus,
  input  logic                 flags_clr,
  output logic [3:0]           sticky_flags,
  output logic [15:0]          op_count
);

  typedef struct packed {
    logic [LANES*W-1:0] data;
    logic [4:0]         rd;
    logic [LANES-1:0]   mask;
    logic [3:0]         flags;
  } entry_t;

  entry_t       mem_q [2];
  entry_t       in_entry;
  entry_t       head;
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;
  logic [LANES-1:0] mask;
  logic         fn;
  logic         fz;
  logic         fc;
  logic         fv;

  // Flags fold only over lanes that will actually be written.
  always_comb begin
    mask = '1;
    if (bus.in_scalar) begin
      mask    = '0;
      mask[0] = 1'b1;
    end
    fn = 1'b0;
    fz = 1'b1;
    fc = 1'b0;
    fv = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        fn = fn | bus.in_flags[i*4+3];
        fz = fz & bus.in_flags[i*4+2];
        fc = fc | bus.in_flags[i*4+1];
        fv = fv | bus.in_flags[i*4+0];
      end
    end
  end

  always_comb begin
    in_entry.data  = bus.in_result;
    in_entry.rd    = bus.in_rd;
    in_entry.mask  = mask;
    in_entry.flags = {fn, fz, fc, fv};
  end

  assign head          = mem_q[rptr_q];
  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign bus.out_data    = head.data;
  assign bus.out_rd      = head.rd;
  assign bus.out_we_mask = head.mask;
  assign bus.out_flags   = head.flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      count_q      <= 2'd0;
      sticky_flags <= 4'd0;
      op_count     <= 16'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_entry;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q   <= ~rptr_q;
        op_count <= op_count + 16'd1;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      // A clear that lands with a pop keeps that pop's flags.
      if (pop && flags_clr) begin
        sticky_flags <= head.flags;
      end else if (pop) begin
        sticky_flags <= sticky_flags | head.flags;
      end else if (flags_clr) begin
        sticky_flags <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_vec_alu_wb_buffer.sv
// Randomized and directed check of vec_alu_wb_buffer against
// a queue-based reference model.
module tb_vec_alu_wb_buffer;
  localparam int LANES = 4;
  localparam int W     = 16;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [3:0]  mask;
    logic [3:0]  flags;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flags_clr;
  logic [3:0]  sticky_flags;
  logic [15:0] op_count;

  vec_alu_wb_buffer_if #(.LANES(LANES), .W(W)) bus ();

  vec_alu_wb_buffer #(.LANES(LANES), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ent_t        q[$];
  logic [3:0]  m_sticky;
  logic [15:0] m_opc;
  bit          fresh;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t make_ent(logic [63:0] d, logic [15:0] f,
                                    logic [4:0] rd, logic sc);
    ent_t e;
    int   nz;
    e.data = d;
    e.rd   = rd;
    e.mask = sc ? 4'b0001 : 4'b1111;
    if (sc) begin
      e.flags = f[3:0];
    end else begin
      nz = 0;
      for (int i = 0; i < 4; i++) if (f[i*4+2]) nz++;
      e.flags[3] = (f[3] | f[7] | f[11] | f[15]);
      e.flags[2] = (nz == 4);
      e.flags[1] = (f[1] | f[5] | f[9] | f[13]);
      e.flags[0] = (f[0] | f[4] | f[8] | f[12]);
    end
    return e;
  endfunction

  task automatic compare_model();
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("sticky", sticky_flags, m_sticky);
    chk("op_count", op_count, m_opc);
    if (q.size() != 0) begin
      chk("out_data", bus.out_data, q[0].data);
      chk("out_rd", bus.out_rd, q[0].rd);
      chk("out_mask", bus.out_we_mask, q[0].mask);
      chk("out_flags", bus.out_flags, q[0].flags);
    end else if (fresh) begin
      chk("rst_data", bus.out_data, 64'd0);
      chk("rst_rd", bus.out_rd, 64'd0);
      chk("rst_mask", bus.out_we_mask, 64'd0);
      chk("rst_flags", bus.out_flags, 64'd0);
    end
  endtask

  task automatic step();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    ent_t p;
    do_push = bus.in_valid && q.size() < 2;
    do_pop  = bus.out_ready && q.size() != 0;
    e = make_ent(bus.in_result, bus.in_flags, bus.in_rd, bus.in_scalar);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_sticky = 4'd0;
      m_opc    = 16'd0;
      fresh    = 1'b1;
    end else begin
      if (do_pop) begin
        p = q.pop_front();
        m_sticky = flags_clr ? p.flags : (m_sticky | p.flags);
        m_opc++;
      end else if (flags_clr) begin
        m_sticky = 4'd0;
      end
      if (do_push) begin
        q.push_back(e);
        fresh = 1'b0;
      end
    end
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(logic v, logic [63:0] d, logic [15:0] f,
                       logic [4:0] rd, logic sc, logic ordy, logic clr);
    bus.in_valid  = v;
    bus.in_result = d;
    bus.in_flags  = f;
    bus.in_rd     = rd;
    bus.in_scalar = sc;
    bus.out_ready = ordy;
    flags_clr     = clr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    m_sticky = 4'd0;
    m_opc    = 16'd0;
    fresh    = 1'b1;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    chk("lit_rst_valid", bus.out_valid, 1'b0);
    chk("lit_rst_ready", bus.in_ready, 1'b1);

    // single vector op
    drive(1, {4{16'h68AC}}, 16'h0000, 5'd3, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("lit_vec_valid", bus.out_valid, 1'b1);
    chk("lit_vec_data", bus.out_data, 64'h68AC68AC68AC68AC);
    chk("lit_vec_mask", bus.out_we_mask, 4'hF);
    chk("lit_vec_flags", bus.out_flags, 4'h0);
    step();
    chk("lit_vec_opc", op_count, 16'd1);

    // scalar op: only lane 0 counts
    drive(1, 64'h1111_2222_3333_0000, 16'h8884, 5'd9, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_sc_mask", bus.out_we_mask, 4'b0001);
    chk("lit_sc_flags", bus.out_flags, 4'b0100);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();

    // backpressure
    do_reset();
    drive(1, 64'hA, 0, 5'd1, 0, 0, 0);
    step();
    drive(1, 64'hB, 0, 5'd2, 0, 0, 0);
    step();
    chk("lit_bp_full", bus.in_ready, 1'b0);
    drive(1, 64'hC, 0, 5'd3, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("lit_bp_head1", bus.out_rd, 5'd1);
    step();
    chk("lit_bp_head2", bus.out_rd, 5'd2);
    chk("lit_bp_ready", bus.in_ready, 1'b1);
    step();
    chk("lit_bp_empty", bus.out_valid, 1'b0);

    // push and pop together at count 1
    drive(1, 64'h7, 0, 5'd7, 0, 0, 0);
    step();
    drive(1, 64'h8, 0, 5'd8, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_pp_valid", bus.out_valid, 1'b1);
    chk("lit_pp_head", bus.out_rd, 5'd8);
    chk("lit_pp_ready", bus.in_ready, 1'b1);
    chk("lit_pp_opc", op_count, 16'd3);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();

    // sticky accumulation and clear-with-pop
    do_reset();
    drive(1, 64'h1, 16'h2222, 5'd4, 0, 0, 0);
    step();
    drive(1, 64'h2, 16'h1111, 5'd5, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    chk("lit_sticky_cv", sticky_flags, 4'b0011);
    drive(1, 64'h3, 16'h8888, 5'd6, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_sticky_clr", sticky_flags, 4'b1000);

    // reset with two buffered entries and op_count 5
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 64'(i), 0, 5'(i), 0, 1, 0);
      step();
    end
    drive(1, 64'h55, 0, 5'd20, 0, 0, 0);
    step();
    chk("lit_pre_opc", op_count, 16'd5);
    chk("lit_pre_full", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    drive(1, 64'h99, 0, 5'd21, 0, 1, 0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst2_valid", bus.out_valid, 1'b0);
    chk("lit_rst2_ready", bus.in_ready, 1'b1);
    chk("lit_rst2_opc", op_count, 16'd0);
    chk("lit_rst2_sticky", sticky_flags, 4'd0);
    chk("lit_rst2_data", bus.out_data, 64'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 2) != 0,
            {$urandom, $urandom},
            16'($urandom),
            5'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_alu_wb_buffer.md
VEC_ALU_WB_BUFFER -- requirements
Module: vec_alu_wb_buffer

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning the number of 16-bit vector ALU lanes collected per operation.
REQ-002 The block SHALL have parameter W, default 16, meaning the lane data width in bits.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, is the synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1, SHALL mean the ALU lanes present a completed operation.
REQ-006 Port in_ready, output, 1, SHALL mean the buffer accepts an operation this cycle.
REQ-007 Port in_result, input, LANES*W, SHALL carry the lane results, with lane i in bits [i*W +: W].
REQ-008 Port in_flags, input, LANES*4, SHALL carry the per-lane flags {N,Z,C,V}, with lane i in bits [i*4 +: 4].
REQ-009 Port in_rd, input, 5, SHALL carry the destination vector register index.
REQ-010 Port in_scalar, input, 1, SHALL mean a scalar operation in which only lane 0 is meaningful.
REQ-011 Port out_valid, output, 1, SHALL mean a writeback entry is presented.
REQ-012 Port out_ready, input, 1, SHALL mean the register file consumes the entry this cycle.
REQ-013 Port out_data, output, LANES*W, SHALL carry the buffered lane results.
REQ-014 Port out_rd, output, 5, SHALL carry the buffered destination index.
REQ-015 Port out_we_mask, output, LANES, SHALL carry the lane write enables.
REQ-016 Port out_flags, output, 4, SHALL carry the combined flags of the presented entry.
REQ-017 Port sticky_flags, output, 4, SHALL carry the accumulated flags of all retired entries.
REQ-018 Port flags_clr, input, 1, SHALL request that sticky_flags be cleared.
REQ-019 Port op_count, output, 16, SHALL carry the count of retired entries.

Function
REQ-020 The storage SHALL be a 2-entry FIFO; each entry holds {data, rd, we_mask, combined flags}.
REQ-021 A push SHALL occur when in_valid && in_ready.
REQ-022 A pop SHALL occur when out_valid && out_ready.
REQ-023 in_ready SHALL equal (count < 2), driven combinationally from the occupancy count only.
REQ-024 A full buffer SHALL deassert in_ready, with no same-cycle pass-through.
REQ-025 out_valid SHALL equal (count != 0).
REQ-026 The outputs SHALL present the head entry; a pushed entry SHALL appear no earlier than the next cycle (latency 1).
REQ-027 Occupancy SHALL follow these rules:
- push only: count+1
- pop only: count-1
- push and pop together: count unchanged, with FIFO order preserved
REQ-028 The read and write pointers SHALL be 1 bit each and wrap 1->0.
REQ-029 we_mask SHALL be {LANES{1'b1}} when in_scalar=0, and 1 (lane 0 only) when in_scalar=1.
REQ-030 Combined flags SHALL be computed over the lanes enabled by we_mask:
- N, C, V: OR of those lanes' bits
- Z: AND of those lanes' Z bits
REQ-031 Data of lanes with a masked write enable SHALL pass unchanged; the register file ignores it.
REQ-032 On each pop, sticky_flags SHALL be OR-updated with the popped entry's out_flags.
REQ-033 flags_clr SHALL zero sticky_flags; when flags_clr and a pop coincide, sticky_flags SHALL become the popped entry's flags.
REQ-034 op_count SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-035 Data entering the buffer SHALL not be modified, truncated or sign-changed.
REQ-036 When in_ready=0, in_* SHALL be ignored.
REQ-037 Output entry fields SHALL remain stable while out_valid=1 && out_ready=0.

Reset
REQ-038 When rst_n=0 at a clock edge, count, both pointers, sticky_flags and op_count SHALL become 0; hence out_valid=0 and in_ready=1 in the following cycle.
REQ-039 Reset asserted mid-operation SHALL discard all buffered entries; a push or pop in that cycle SHALL have no effect.
REQ-040 After reset, out_data, out_rd, out_we_mask and out_flags SHALL read 0 (storage cleared).

Verification
REQ-041 Single vector op: in_result lanes all 16'h68AC, in_flags 4'b0000, rd=3, in_scalar=0, out_ready=1 -> next cycle out_valid=1, out_data lanes 68AC, out_we_mask=4'hF, out_flags=0, op_count=1 after the pop.
REQ-042 Scalar op: lane0=16'h0000 with Z=1, lanes 1-3 nonzero with Z=0, in_scalar=1 -> out_we_mask=4'b0001, out_flags Z=1.
REQ-043 Backpressure: out_ready=0, push 3 ops (rd 1, 2, 3) -> in_ready=0 after 2 pushes, rd=3 is not accepted; then out_ready=1 -> pops rd 1 then 2, in_ready returns to 1.
REQ-044 Simultaneous push and pop at count=1 -> count stays 1, output order is preserved, op_count +1.
REQ-045 Sticky flags: pop an entry with C=1, then one with V=1 -> sticky=4'b0011; flags_clr together with a pop whose N=1 -> sticky=4'b1000.
REQ-046 Reset with 2 entries buffered and op_count=5 -> next cycle out_valid=0, in_ready=1, op_count=0, sticky_flags=0.
